// File: rtl/mod_pkg.sv
// Widths shared by mod_byte_fifo and data_mod_fsm so both ends of the byte
// stream agree on data and pointer sizes.
package mod_pkg;
  localparam int MOD_DW         = 8;
  localparam int MOD_FIFO_DEPTH = 16;
  localparam int MOD_FIFO_AW    = 4;
endpackage

// File: rtl/mod_fifo_regfile.sv
// DEPTH x DW storage array for the byte FIFO: one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module mod_fifo_regfile
  import mod_pkg::*;
#(
  parameter int DW    = MOD_DW,
  parameter int DEPTH = MOD_FIFO_DEPTH,
  parameter int AW    = MOD_FIFO_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mod_byte_fifo.sv
// First-word-fall-through byte FIFO feeding data_mod_fsm, with sticky
// overflow/underflow flags for the control/status logic.
module mod_byte_fifo
  import mod_pkg::*;
#(
  parameter int DW    = MOD_DW,
  parameter int DEPTH = MOD_FIFO_DEPTH,
  parameter int AW    = MOD_FIFO_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_err,
  output logic          rdy,
  output logic [DW-1:0] data_in,
  input  logic          rd,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
);

  // Handshake: the consumer may pop only while rdy=1; a rd with rdy=1 consumes
  // the byte on data_in at that edge. A rd with rdy=0 is a violation (udf) and
  // a wr_en with full=1 is a violation (ovf); neither changes the FIFO contents.

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] head;
  logic          do_wr;
  logic          do_rd;

  assign rdy   = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd && rdy;

  mod_fifo_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign data_in = rdy ? head : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh violation outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
      if (rd && !rdy) begin
        udf <= 1'b1;
      end else if (clr_err) begin
        udf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_byte_fifo.sv
// Directed bench for mod_byte_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/drain, overflow, wrap and streaming.
module tb_mod_byte_fifo;
  import mod_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_err;
  logic       rdy;
  logic [7:0] data_in;
  logic       rd;
  logic       full;
  logic [4:0] count;
  logic       ovf;
  logic       udf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd;
    logic       clr_err;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[12];

  mod_byte_fifo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_err (clr_err),
    .rdy     (rdy),
    .data_in (data_in),
    .rd      (rd),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_rdy"}, rdy, 1);
    check({name, "_data"}, data_in, exp);
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  initial begin
    idle();

    // reset held with wr_en asserted
    reset_n = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    step();
    step();
    check("rst_rdy", rdy, 0);
    check("rst_count", count, 0);
    check("rst_data", data_in, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    idle();
    reset_n = 1'b1;
    step();
    check("rst_release_count", count, 0);

    // vector table: {wr_en, wr_data, rd, clr_err, rdy, data_in, count, full, ovf, udf}
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      rd      = vecs[i].rd;
      clr_err = vecs[i].clr_err;
      step();
      idle();
      check($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d_data", i), data_in, vecs[i].exp_data);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      check($sformatf("vec%0d_udf", i), udf, vecs[i].exp_udf);
    end
    pop_check("vec_drain", 8'h55);
    check("vec_drain_count", count, 0);

    // fill / drain
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i));
    check("drain_rdy", rdy, 0);
    check("drain_count", count, 0);
    check("drain_data", data_in, 0);

    // overflow, then simultaneous wr+rd while full
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    push(8'hAA);
    check("ovf_flag", ovf, 1);
    check("ovf_count", count, 16);
    check("ovf_head", data_in, 8'h10);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", ovf, 0);
    wr_en   = 1'b1;
    wr_data = 8'hBB;
    rd      = 1'b1;
    step();
    idle();
    check("full_wr_rd_count", count, 15);
    check("full_wr_rd_ovf", ovf, 1);
    check("full_wr_rd_head", data_in, 8'h11);
    for (int i = 1; i < 16; i++) pop_check($sformatf("ovf_drain%0d", i), 8'h10 + 8'(i));
    check("ovf_drain_count", count, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // steady-state simultaneous access at count=5 with pointer wrap
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      push(8'h50 + 8'(i));
      exp_q.push_back(8'h50 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("sim%0d_head", i), data_in, exp_q[0]);
      wr_en   = 1'b1;
      wr_data = 8'h60 + 8'(i);
      rd      = 1'b1;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h60 + 8'(i));
      step();
      idle();
      check($sformatf("sim%0d_count", i), count, 5);
    end
    for (int i = 0; i < 5; i++) pop_check($sformatf("sim_drain%0d", i), exp_q[i]);
    exp_q.delete();
    check("sim_end_count", count, 0);
    check("sim_end_flags", {ovf, udf}, 0);

    // end-to-end streaming with a consumer that pops whenever rdy is high
    begin
      int sent   = 0;
      int popped = 0;
      int cyc    = 0;
      while (popped < 10 && cyc < 100) begin
        wr_en   = (sent < 10);
        wr_data = 8'(sent);
        if (sent < 10) begin
          exp_q.push_back(8'(sent));
          sent++;
        end
        rd = rdy;
        if (rdy) begin
          if (exp_q.size() == 0) begin
            check("e2e_unexpected_pop", 1, 0);
          end else begin
            check($sformatf("e2e_pop%0d", popped), data_in, exp_q.pop_front());
          end
          popped++;
        end
        step();
        idle();
        cyc++;
      end
      check("e2e_popped", popped, 10);
      check("e2e_queue_empty", exp_q.size(), 0);
      check("e2e_count", count, 0);
      check("e2e_ovf", ovf, 0);
      check("e2e_udf", udf, 0);
    end

    // reset mid-operation beats same-cycle wr_en/rd
    rd = 1'b1;
    step();
    idle();
    check("mid_udf_set", udf, 1);
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    reset_n = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hCC;
    rd      = 1'b1;
    step();
    idle();
    check("mid_rst_count", count, 0);
    check("mid_rst_rdy", rdy, 0);
    check("mid_rst_data", data_in, 0);
    check("mid_rst_udf", udf, 0);
    reset_n = 1'b1;
    step();
    check("mid_rel_count", count, 0);
    push(8'h99);
    check("mid_after_head", data_in, 8'h99);
    check("mid_after_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
